// File: rtl/alu_seq_n_if.sv
// Operand/opcode request and result bus between a requester and alu_seq_n.
// The master drives the operation request; the slave returns status and the registered result.
interface alu_seq_n_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2:0]           Opcode;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   ALUout;
    logic                 Cout;

    modport master (
        output start, A, B, Opcode,
        input  busy, done, ALUout, Cout
    );

    modport slave (
        input  start, A, B, Opcode,
        output busy, done, ALUout, Cout
    );
endinterface

// File: rtl/alu_seq_n.sv
// Sequential ALU: single-cycle add/sub/shift/logic ops and a radix-2 shift-add multiplier.
// Results are registered and announced by a one-cycle done pulse.
module alu_seq_n #(
    parameter int unsigned WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_seq_n_if.slave   bus
);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_LSH = 3'b011;
    localparam logic [2:0] OP_RSH = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;

    state_t            state, state_n;
    logic [W2-1:0]     acc, acc_n;
    logic [W2-1:0]     mcand, mcand_n;
    logic [WIDTH-1:0]  mplier, mplier_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [W2-1:0]     alu_out, alu_out_n;
    logic              cout, cout_n;
    logic              done, done_n;
    logic              busy, busy_n;

    // Single-cycle result computed straight from the request bus.
    logic [W2-1:0]     res_c;
    logic              res_cout_c;
    logic [WIDTH:0]    sum_c;
    logic [W2-1:0]     cat_c;

    always_comb begin
        sum_c      = (WIDTH+1)'(bus.A) + (WIDTH+1)'(bus.B);
        cat_c      = {bus.A, bus.B};
        res_c      = '0;
        res_cout_c = 1'b0;
        case (bus.Opcode)
            OP_ADD: begin
                res_c      = W2'(sum_c);
                res_cout_c = sum_c[WIDTH];
            end
            OP_SUB: begin
                if (bus.A >= bus.B) begin
                    res_c = W2'(bus.A - bus.B);
                end else begin
                    res_c      = W2'(bus.B - bus.A);
                    res_cout_c = 1'b1;
                end
            end
            OP_LSH:  res_c = cat_c << 1;
            OP_RSH:  res_c = cat_c >> 1;
            OP_AND:  res_c = W2'(bus.A & bus.B);
            OP_OR:   res_c = W2'(bus.A | bus.B);
            OP_XOR:  res_c = W2'(bus.A ^ bus.B);
            default: res_c = '0;
        endcase
    end

    // Next-state and datapath update.
    logic [W2-1:0] acc_sum_c;

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        mcand_n   = mcand;
        mplier_n  = mplier;
        cnt_n     = cnt;
        alu_out_n = alu_out;
        cout_n    = cout;
        done_n    = 1'b0;
        busy_n    = busy;
        acc_sum_c = acc + (mplier[0] ? mcand : W2'(0));

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.Opcode == OP_MUL) begin
                        state_n  = S_MUL;
                        acc_n    = '0;
                        cnt_n    = '0;
                        mcand_n  = W2'(bus.A);
                        mplier_n = bus.B;
                        busy_n   = 1'b1;
                    end else begin
                        alu_out_n = res_c;
                        cout_n    = res_cout_c;
                        done_n    = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_n    = acc_sum_c;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt + CW'(1);
                // Last multiplier bit: publish the product on this same edge.
                if (cnt == CW'(WIDTH - 1)) begin
                    alu_out_n = acc_sum_c;
                    cout_n    = 1'b0;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            alu_out <= '0;
            cout    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            mcand   <= mcand_n;
            mplier  <= mplier_n;
            cnt     <= cnt_n;
            alu_out <= alu_out_n;
            cout    <= cout_n;
            done    <= done_n;
            busy    <= busy_n;
        end
    end

    assign bus.ALUout = alu_out;
    assign bus.Cout   = cout;
    assign bus.done   = done;
    assign bus.busy   = busy;
endmodule
